// File: rtl/synthia_pkg.sv
// Shared types and constants for the Synthia key-conditioning front end.
// Holds the note/mode widths and the waveform-mode enum used by the tone path.
package synthia_pkg;

    localparam int NUM_KEYS   = 13;
    localparam int NOTE_IDX_W = 4;
    localparam int MODE_W     = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SQUARE = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SAW    = 2'd2
    } mode_e;

    // Three-way rotation; the unused encoding 3 folds back to SQUARE.
    function automatic mode_e mode_next(input mode_e m);
        case (m)
            MODE_SQUARE: return MODE_TRI;
            MODE_TRI:    return MODE_SAW;
            default:     return MODE_SQUARE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton line: 2-FF synchronizer followed by a mismatch-count debouncer.
// Latency DEBOUNCE_CYCLES+2 edges from raw change to stable flip; no backpressure.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // The >= also acts as saturation: the count can never pass CNT_LAST.
        if (sync2_q != stable_q) begin
            if (cnt_q >= CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/synthia_key_conditioner.sv
// Debounces note/mode/octave keys and produces registered note index, mode and octave selects.
// Latency DEBOUNCE_CYCLES+3 edges from raw key change to outputs; no backpressure (level/strobe only).
module synthia_key_conditioner
    import synthia_pkg::*;
#(
    parameter int NUM_KEYS        = synthia_pkg::NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_KEYS-1:0]   pb,
    input  logic                  modes,
    input  logic                  octaves,
    output logic                  note_valid,
    output logic [NOTE_IDX_W-1:0] note_idx,
    output logic                  note_change,
    output logic [MODE_W-1:0]     mode_sel,
    output logic                  mode_pulse,
    output logic                  octave_sel,
    output logic                  octave_pulse
);

    localparam int NUM_LINES = NUM_KEYS + 2;

    logic [NUM_LINES-1:0] raw_lines;
    logic [NUM_LINES-1:0] deb_lines;
    logic [NUM_KEYS-1:0]  deb_notes;
    logic                 deb_mode;
    logic                 deb_octave;

    assign raw_lines = {octaves, modes, pb};

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_lines[g]),
            .stable (deb_lines[g])
        );
    end

    assign deb_notes  = deb_lines[NUM_KEYS-1:0];
    assign deb_mode   = deb_lines[NUM_KEYS];
    assign deb_octave = deb_lines[NUM_KEYS+1];

    logic                  note_valid_q, note_valid_d;
    logic [NOTE_IDX_W-1:0] note_idx_q, note_idx_d;
    logic                  note_change_q, note_change_d;
    mode_e                 mode_sel_q, mode_sel_d;
    logic                  mode_pulse_q, mode_pulse_d;
    logic                  mode_prev_q, mode_prev_d;
    logic                  octave_sel_q, octave_sel_d;
    logic                  octave_pulse_q, octave_pulse_d;
    logic                  octave_prev_q, octave_prev_d;
    logic                  mode_rise;
    logic                  octave_rise;

    always_comb begin
        note_valid_d = |deb_notes;
        note_idx_d   = '0;
        // Ascending scan: the last set key seen is the highest, so it wins.
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (deb_notes[i]) begin
                note_idx_d = NOTE_IDX_W'(i);
            end
        end
        note_change_d = {note_valid_d, note_idx_d} != {note_valid_q, note_idx_q};

        mode_rise    = deb_mode & ~mode_prev_q;
        mode_prev_d  = deb_mode;
        mode_pulse_d = mode_rise;
        mode_sel_d   = mode_rise ? mode_next(mode_sel_q) : mode_sel_q;

        octave_rise    = deb_octave & ~octave_prev_q;
        octave_prev_d  = deb_octave;
        octave_pulse_d = octave_rise;
        octave_sel_d   = octave_sel_q ^ octave_rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_valid_q   <= 1'b0;
            note_idx_q     <= '0;
            note_change_q  <= 1'b0;
            mode_sel_q     <= MODE_SQUARE;
            mode_pulse_q   <= 1'b0;
            mode_prev_q    <= 1'b0;
            octave_sel_q   <= 1'b0;
            octave_pulse_q <= 1'b0;
            octave_prev_q  <= 1'b0;
        end else begin
            note_valid_q   <= note_valid_d;
            note_idx_q     <= note_idx_d;
            note_change_q  <= note_change_d;
            mode_sel_q     <= mode_sel_d;
            mode_pulse_q   <= mode_pulse_d;
            mode_prev_q    <= mode_prev_d;
            octave_sel_q   <= octave_sel_d;
            octave_pulse_q <= octave_pulse_d;
            octave_prev_q  <= octave_prev_d;
        end
    end

    assign note_valid   = note_valid_q;
    assign note_idx     = note_idx_q;
    assign note_change  = note_change_q;
    assign mode_sel     = mode_sel_q;
    assign mode_pulse   = mode_pulse_q;
    assign octave_sel   = octave_sel_q;
    assign octave_pulse = octave_pulse_q;

endmodule

// File: tb/tb_synthia_key_conditioner.sv
// Directed bench for synthia_key_conditioner with DEBOUNCE_CYCLES=4, checked against a
// window-based behavioural model every cycle plus hand-computed literal expectations.
module tb_synthia_key_conditioner;

    localparam int D  = 4;
    localparam int NK = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] pb;
    logic          modes;
    logic          octaves;
    logic          note_valid;
    logic [3:0]    note_idx;
    logic          note_change;
    logic [1:0]    mode_sel;
    logic          mode_pulse;
    logic          octave_sel;
    logic          octave_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    synthia_key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pb           (pb),
        .modes        (modes),
        .octaves      (octaves),
        .note_valid   (note_valid),
        .note_idx     (note_idx),
        .note_change  (note_change),
        .mode_sel     (mode_sel),
        .mode_pulse   (mode_pulse),
        .octave_sel   (octave_sel),
        .octave_pulse (octave_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A line's debounced level becomes v once the last D synchronized samples
    // (raw samples taken two edges earlier) are all v; otherwise it holds.
    logic [D:0][NK+1:0] hist;
    logic [NK+1:0]      m_deb, m_deb_old;
    logic               ev, ec, emp, eo, eop;
    logic [3:0]         ei;
    logic [1:0]         em;
    int                 mode_cnt;

    function automatic logic [NK+1:0] deb_next(input logic [D:0][NK+1:0] h, input logic [NK+1:0] cur);
        logic [NK+1:0] r;
        r = cur;
        for (int l = 0; l < NK + 2; l++) begin
            int ones;
            ones = 0;
            for (int j = 1; j <= D; j++) ones += int'(h[j][l]);
            if (ones == D) r[l] = 1'b1;
            else if (ones == 0) r[l] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [3:0] hi_idx(input logic [NK-1:0] k);
        int v;
        int t;
        v = 0;
        t = int'(k);
        while (t > 1) begin
            t = t / 2;
            v++;
        end
        return 4'(v);
    endfunction

    logic m_mrise, m_orise;
    assign m_mrise = m_deb[NK]   & ~m_deb_old[NK];
    assign m_orise = m_deb[NK+1] & ~m_deb_old[NK+1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            m_deb     <= '0;
            m_deb_old <= '0;
            ev        <= 1'b0;
            ei        <= '0;
            ec        <= 1'b0;
            em        <= '0;
            emp       <= 1'b0;
            eo        <= 1'b0;
            eop       <= 1'b0;
            mode_cnt  <= 0;
        end else begin
            hist      <= {hist[D-1:0], {octaves, modes, pb}};
            m_deb     <= deb_next(hist, m_deb);
            m_deb_old <= m_deb;
            ev        <= |m_deb[NK-1:0];
            ei        <= hi_idx(m_deb[NK-1:0]);
            ec        <= {(|m_deb[NK-1:0]), hi_idx(m_deb[NK-1:0])} != {ev, ei};
            mode_cnt  <= mode_cnt + int'(m_mrise);
            em        <= 2'((mode_cnt + int'(m_mrise)) % 3);
            emp       <= m_mrise;
            eo        <= eo ^ m_orise;
            eop       <= m_orise;
        end
    end

    logic [11:0] dut_vec, mdl_vec;
    assign dut_vec = {note_valid, note_idx, note_change, mode_sel, mode_pulse, octave_sel, octave_pulse};
    assign mdl_vec = {ev, ei, ec, em, emp, eo, eop};

    always @(negedge clk) begin
        chk("cycle_model {valid,idx,chg,mode,mpulse,oct,opulse}", 32'(dut_vec), 32'(mdl_vec));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        int exp_modes [4];
        exp_modes = '{1, 2, 0, 1};

        // Reset with every key held.
        reset   = 1'b1;
        pb      = 13'h1FFF;
        modes   = 1'b1;
        octaves = 1'b1;
        step(3);
        chk("reset_all_zero", 32'(dut_vec), 32'd0);
        reset = 1'b0;
        step(6);
        chk("rst_release_edge6_valid", 32'(note_valid), 0);
        chk("rst_release_edge6_mpulse", 32'(mode_pulse), 0);
        step(1);
        chk("rst_release_edge7_valid", 32'(note_valid), 1);
        chk("rst_release_edge7_idx", 32'(note_idx), 12);
        chk("rst_release_edge7_mpulse", 32'(mode_pulse), 1);
        chk("rst_release_edge7_opulse", 32'(octave_pulse), 1);
        chk("rst_release_edge7_mode", 32'(mode_sel), 1);
        chk("rst_release_edge7_oct", 32'(octave_sel), 1);
        step(1);
        chk("rst_release_mpulse_one_cycle", 32'(mode_pulse), 0);
        pb = '0; modes = 1'b0; octaves = 1'b0;
        step(10);

        // Single key press and release.
        pb = 13'h0001;
        step(6);
        chk("single_edge6_change", 32'(note_change), 0);
        step(1);
        chk("single_press_valid", 32'(note_valid), 1);
        chk("single_press_idx", 32'(note_idx), 0);
        chk("single_press_change", 32'(note_change), 1);
        step(13);
        pb = '0;
        step(6);
        chk("single_rel_edge6_valid", 32'(note_valid), 1);
        step(1);
        chk("single_rel_valid", 32'(note_valid), 0);
        chk("single_rel_change", 32'(note_change), 1);
        step(1);
        chk("single_rel_change_one_cycle", 32'(note_change), 0);
        step(5);

        // Bounce rejection on pb[9]: 1/2/3-cycle high pulses separated by 2-cycle gaps.
        for (int w = 1; w <= 3; w++) begin
            pb[9] = 1'b1;
            step(w);
            pb[9] = 1'b0;
            step(2);
        end
        chk("bounce_no_valid", 32'(note_valid), 0);
        pb[9] = 1'b1;
        step(6);
        chk("bounce_edge6_valid", 32'(note_valid), 0);
        step(1);
        chk("bounce_final_valid", 32'(note_valid), 1);
        chk("bounce_final_idx", 32'(note_idx), 9);
        pb = '0;
        step(10);

        // Chord priority.
        pb = 13'h0811;
        step(7);
        chk("chord_idx11", 32'(note_idx), 11);
        pb = 13'h0011;
        step(6);
        chk("chord_edge6_idx", 32'(note_idx), 11);
        step(1);
        chk("chord_idx4", 32'(note_idx), 4);
        chk("chord_idx4_change", 32'(note_change), 1);
        pb = '0;
        step(10);

        // Mode wrap from a fresh reset.
        pulse_reset();
        step(2);
        for (int i = 0; i < 4; i++) begin
            modes = 1'b1;
            step(7);
            chk("mode_wrap_sel", 32'(mode_sel), 32'(exp_modes[i]));
            chk("mode_wrap_pulse", 32'(mode_pulse), 1);
            step(1);
            chk("mode_wrap_pulse_drop", 32'(mode_pulse), 0);
            modes = 1'b0;
            step(10);
            chk("mode_wrap_release_hold", 32'(mode_sel), 32'(exp_modes[i]));
        end

        // Mid-operation reset with mode=2, octave=1, during a pb[5] debounce.
        modes = 1'b1;   step(8); modes = 1'b0;   step(10);
        octaves = 1'b1; step(8); octaves = 1'b0; step(10);
        chk("pre_reset_mode2", 32'(mode_sel), 2);
        chk("pre_reset_oct1", 32'(octave_sel), 1);
        pb = 13'h0020;
        step(2);
        #2 reset = 1'b1;
        #1 chk("mid_reset_async_zero", 32'(dut_vec), 32'd0);
        step(2);
        reset = 1'b0;
        step(6);
        chk("mid_reset_edge6_valid", 32'(note_valid), 0);
        step(1);
        chk("mid_reset_idx5", 32'(note_idx), 5);
        chk("mid_reset_valid", 32'(note_valid), 1);
        chk("mid_reset_mode0", 32'(mode_sel), 0);
        chk("mid_reset_oct0", 32'(octave_sel), 0);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/synthia_key_conditioner.md
# synthia_key_conditioner

Input conditioning stage directly upstream of the Synthia tone generator. It takes the 15 raw pushbutton lines (13 note keys, mode key, octave key), then synchronizes and debounces each one. From the debounced keys it produces:
- a registered note index, with highest key winning;
- a waveform-mode selector that advances once per mode-key press;
- an octave selector that toggles once per octave-key press.

The tone generator consumes these outputs directly, so it never sees metastable or bouncing inputs.

## Interface
Parameters:
- NUM_KEYS, 13, number of note keys.
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a level change (1 ms at 10 MHz); legal range 2..65535.

Ports:
- clk  in  1  system clock, 10 MHz.
- reset  in  1  asynchronous, active-high reset.
- pb  in  NUM_KEYS  raw note keys; bit 0 is low C, bit 12 is high C.
- modes  in  1  raw mode-advance key.
- octaves  in  1  raw octave-toggle key.
- note_valid  out  1  at least one debounced note key is held.
- note_idx  out  4  index of the highest held debounced note key; 0 when note_valid=0.
- note_change  out  1  one-cycle strobe when note_valid or note_idx changes.
- mode_sel  out  2  current waveform: 0 SQUARE, 1 TRI, 2 SAW.
- mode_pulse  out  1  one-cycle strobe on each accepted mode press.
- octave_sel  out  1  0 base octave, 1 upper octave.
- octave_pulse  out  1  one-cycle strobe on each accepted octave press.

## Operation
- Synchronizer: a 2-FF chain on each of the 15 raw inputs. All synchronizer flops reset to 0.
- Debouncer, one per line:
  - Holds a stable level (reset 0) and a mismatch counter (reset 0).
  - Each cycle the synchronized value differs from stable, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, stable flips and the counter clears.
  - Any cycle the synchronized value equals stable, the counter clears, so a glitch shorter than DEBOUNCE_CYCLES produces no change.
  - The counter saturates and never wraps.
- Note encoder (registered):
  - note_valid = OR of the debounced note keys.
  - note_idx = highest set index, so several simultaneous keys resolve to the highest.
  - note_change is asserted for the cycle in which the registered {note_valid, note_idx} differs from its previous value.
- Mode: a rising edge of debounced modes asserts mode_pulse for one cycle and advances mode_sel 0→1→2→0. Value 3 is never produced. A falling edge does nothing.
- Octave: a rising edge of debounced octaves asserts octave_pulse for one cycle and toggles octave_sel.
- Events on different lines are independent. Simultaneous acceptance of a note, mode and octave change in the same cycle updates all outputs in that cycle.
- Reset, including mid-debounce or mid-press:
  - All outputs are 0: note_valid, note_idx, note_change, mode_sel, mode_pulse, octave_sel, octave_pulse.
  - All counters, stable levels and synchronizers clear.
  - A key held through reset release is accepted as a new press DEBOUNCE_CYCLES+3 edges later.

## Timing
- Let edge 1 be the first rising edge that samples a new raw level that then stays constant. The sequence is:
  - edge 1: FF1 captures the new level.
  - edge 2: FF2 captures it.
  - edges 3..DEBOUNCE_CYCLES+2: mismatch count; stable flips on edge DEBOUNCE_CYCLES+2.
  - edge DEBOUNCE_CYCLES+3: registered outputs and strobes update.
- Total latency is exactly DEBOUNCE_CYCLES+3 edges, identical for press and release and for every line.
- Strobes are high for exactly one cycle per accepted edge.
- Minimum press accepted: DEBOUNCE_CYCLES cycles of stable synchronized level.
- There is no backpressure; outputs are level or strobe only.

## Structure
- Shared package synthia_pkg contains:
  - NUM_KEYS;
  - the mode enum (MODE_SQUARE=0, MODE_TRI=1, MODE_SAW=2);
  - NOTE_IDX_W=4;
  - the mode width.
- Sub-module key_debounce (one bit: 2-FF sync, counter, stable level, parameter DEBOUNCE_CYCLES) is instantiated 15 times.
- The top level holds the priority encoder, edge detectors, mode counter and octave flop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset check:
  - Assert reset with pb=13'h1FFF, modes=1, octaves=1, then release and hold the inputs.
  - All outputs read 0 during reset.
  - note_valid=1, note_idx=12, mode_pulse=1 and octave_pulse=1 first appear exactly 7 edges after release.
- Single key:
  - pb=13'h0001 held for 20 cycles, then released.
  - note_valid=1, note_idx=0 and note_change=1 after 7 edges.
  - On release, note_valid=0 after 7 edges, with one note_change strobe.
- Bounce rejection:
  - pb[9] toggles with 1,2,3-cycle pulses, then holds high.
  - No output change during the pulses.
  - note_idx=9 exactly 7 edges after the final rising edge.
- Chord priority:
  - pb[0], pb[4] and pb[11] pressed together → note_idx=11.
  - Release pb[11] → note_idx=4 after 7 edges.
- Mode wrap:
  - Four debounced mode presses.
  - mode_sel goes 1, 2, 0, 1, with four single-cycle mode_pulse strobes and no change on releases.
- Mid-operation reset:
  - Assert reset 2 cycles into a pb[5] debounce with mode_sel=2 and octave_sel=1.
  - All outputs are 0 immediately (asynchronous).
  - After release with pb[5] still held, note_idx=5 after 7 edges.
